// File: rtl/sid_pkg.sv
// Shared SID envelope definitions: widths, register offsets, state encoding,
// rate-period and exponential-divisor lookups.
package sid_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned VOICE_W  = 12;
  localparam int unsigned ENV_W    = 8;
  localparam int unsigned RATE_W   = 15;
  localparam int unsigned EXP_W    = 5;

  localparam int unsigned REG_CTRL = 4;
  localparam int unsigned REG_AD   = 5;
  localparam int unsigned REG_SR   = 6;

  typedef enum logic [1:0] {
    ATTACK  = 2'd0,
    DECAY   = 2'd1,
    RELEASE = 2'd2
  } env_state_t;

  typedef struct packed {
    logic       gate;
    logic [3:0] atkRate;
    logic [3:0] decRate;
    logic [3:0] susLvl;
    logic [3:0] relRate;
  } env_regs_t;

  // Rate period in clkEn ticks for a 4-bit rate selector
  function automatic logic [RATE_W-1:0] sid_rate_period(input logic [3:0] rate);
    logic [RATE_W-1:0] p;
    case (rate)
      4'd0:    p = 15'd9;
      4'd1:    p = 15'd32;
      4'd2:    p = 15'd63;
      4'd3:    p = 15'd95;
      4'd4:    p = 15'd149;
      4'd5:    p = 15'd220;
      4'd6:    p = 15'd267;
      4'd7:    p = 15'd313;
      4'd8:    p = 15'd392;
      4'd9:    p = 15'd977;
      4'd10:   p = 15'd1954;
      4'd11:   p = 15'd3126;
      4'd12:   p = 15'd3907;
      4'd13:   p = 15'd11720;
      4'd14:   p = 15'd19532;
      default: p = 15'd31251;
    endcase
    return p;
  endfunction

  // Piecewise-exponential divisor applied to decay/release steps
  function automatic logic [EXP_W-1:0] sid_exp_div(input logic [ENV_W-1:0] env);
    logic [EXP_W-1:0] d;
    if (env >= 8'h5e)      d = 5'd1;
    else if (env >= 8'h37) d = 5'd2;
    else if (env >= 8'h1b) d = 5'd4;
    else if (env >= 8'h0f) d = 5'd8;
    else if (env >= 8'h07) d = 5'd16;
    else                   d = 5'd30;
    return d;
  endfunction

endpackage

// File: rtl/sid_env_vca.sv
// Voice VCA: centres the unsigned waveform, scales it by the envelope and
// registers the signed result every clk.
module sid_env_vca
  import sid_pkg::*;
(
  input  logic               clk,
  input  logic               iRstN,
  input  logic [VOICE_W-1:0] iVoice,
  input  logic [ENV_W-1:0]   iEnv,
  output logic [VOICE_W-1:0] oOut
);

  localparam int unsigned PROD_W = VOICE_W + ENV_W + 2;

  logic signed [VOICE_W:0]   centered;
  logic signed [ENV_W:0]     gain;
  logic signed [PROD_W-1:0]  product;

  // Subtracting 'h800 from a 12-bit code is an MSB flip, sign-extended to 13 bits
  assign centered = $signed({{2{~iVoice[VOICE_W-1]}}, iVoice[VOICE_W-2:0]});
  assign gain     = $signed({1'b0, iEnv});
  assign product  = PROD_W'(centered) * PROD_W'(gain);

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) oOut <= '0;
    else        oOut <= VOICE_W'(product >>> ENV_W);
  end

endmodule

// File: rtl/sid_envelope.sv
// Per-voice ADSR envelope generator with VCA; envelope timing advances on clkEn,
// register writes and the VCA run on every clk.
module sid_envelope
  import sid_pkg::*;
#(
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               iRstN,
  input  logic               clkEn,
  input  logic               iWE,
  input  logic [ADDR_W-1:0]  iAddr,
  input  logic [DATA_W-1:0]  iData,
  input  logic [VOICE_W-1:0] iVoice,
  output logic [ENV_W-1:0]   oEnv,
  output logic [VOICE_W-1:0] oOut
);

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(BASE_ADDR + REG_CTRL);
  localparam logic [ADDR_W-1:0] ADDR_AD     = ADDR_W'(BASE_ADDR + REG_AD);
  localparam logic [ADDR_W-1:0] ADDR_SR     = ADDR_W'(BASE_ADDR + REG_SR);
  localparam logic [ENV_W-1:0]  ENV_MAX     = '1;
  localparam logic [ENV_W-1:0]  ENV_PRE_MAX = ENV_MAX - ENV_W'(1);

  env_regs_t         regs;
  env_state_t        state, stateNext;
  logic [ENV_W-1:0]  env, envNext;
  logic [RATE_W-1:0] rateCnt, rateCntNext;
  logic [EXP_W-1:0]  expCnt, expCntNext;
  logic              gateLag, gateLagNext;
  logic [3:0]        rateSel;
  logic [ENV_W-1:0]  susTarget;
  logic              rateTick, gateRise, gateFall, gateEdge, expDone, expActive;

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      regs <= '0;
    end else if (iWE) begin
      if (iAddr == ADDR_CTRL) regs.gate <= iData[0];
      if (iAddr == ADDR_AD) begin
        regs.atkRate <= iData[7:4];
        regs.decRate <= iData[3:0];
      end
      if (iAddr == ADDR_SR) begin
        regs.susLvl  <= iData[7:4];
        regs.relRate <= iData[3:0];
      end
    end
  end

  always_comb begin
    case (state)
      ATTACK:  rateSel = regs.atkRate;
      DECAY:   rateSel = regs.decRate;
      default: rateSel = regs.relRate;
    endcase
  end

  // Equality-only compare: a shortened period makes the counter run through 'h7fff first
  assign rateTick  = clkEn && (rateCnt == sid_rate_period(rateSel) - RATE_W'(1));
  assign gateRise  = regs.gate && !gateLag;
  assign gateFall  = !regs.gate && gateLag;
  assign gateEdge  = gateRise || gateFall;
  assign susTarget = {regs.susLvl, regs.susLvl};
  assign expDone   = (expCnt == sid_exp_div(env) - EXP_W'(1));
  assign expActive = (state == DECAY) ? (env > susTarget)
                                      : ((state == RELEASE) && (env != '0));

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      state   <= RELEASE;
      env     <= '0;
      rateCnt <= '0;
      expCnt  <= '0;
      gateLag <= 1'b0;
    end else begin
      state   <= stateNext;
      env     <= envNext;
      rateCnt <= rateCntNext;
      expCnt  <= expCntNext;
      gateLag <= gateLagNext;
    end
  end

  // Gate edges win over the attack-peak transition
  always_comb begin
    stateNext = state;
    if (clkEn) begin
      if (gateRise)
        stateNext = ATTACK;
      else if (gateFall)
        stateNext = RELEASE;
      else if ((state == ATTACK) && rateTick && (env >= ENV_PRE_MAX))
        stateNext = DECAY;
    end
  end

  always_comb begin
    envNext     = env;
    expCntNext  = expCnt;
    rateCntNext = rateCnt;
    gateLagNext = gateLag;
    if (clkEn) begin
      gateLagNext = regs.gate;
      rateCntNext = rateTick ? '0 : rateCnt + RATE_W'(1);
      if (rateTick && !gateEdge) begin
        if (state == ATTACK) begin
          if (env != ENV_MAX) envNext = env + ENV_W'(1);
          expCntNext = '0;
        end else if (expActive) begin
          if (expDone) begin
            envNext    = env - ENV_W'(1);
            expCntNext = '0;
          end else begin
            expCntNext = expCnt + EXP_W'(1);
          end
        end
      end
    end
  end

  assign oEnv = env;

  sid_env_vca uVca (
    .clk    (clk),
    .iRstN  (iRstN),
    .iVoice (iVoice),
    .iEnv   (env),
    .oOut   (oOut)
  );

endmodule

// File: tb/tb_sid_envelope.sv
// Directed scoreboard bench for sid_envelope: expectations are queued with the
// stimulus and popped when the corresponding DUT output is sampled.
module tb_sid_envelope;
  import sid_pkg::*;

  localparam int unsigned BASE = 7;
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(BASE + REG_CTRL);
  localparam logic [ADDR_W-1:0] A_SR   = ADDR_W'(BASE + REG_SR);
  localparam int BUDGET = 4000;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic               clk = 1'b0;
  logic               iRstN;
  logic               clkEn;
  logic               iWE;
  logic [ADDR_W-1:0]  iAddr;
  logic [DATA_W-1:0]  iData;
  logic [VOICE_W-1:0] iVoice;
  logic [ENV_W-1:0]   oEnv;
  logic [VOICE_W-1:0] oOut;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   enCount = 0;
  int   n;

  always #5 clk = ~clk;

  sid_envelope #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .iRstN  (iRstN),
    .clkEn  (clkEn),
    .iWE    (iWE),
    .iAddr  (iAddr),
    .iData  (iData),
    .iVoice (iVoice),
    .oEnv   (oEnv),
    .oOut   (oOut)
  );

  task automatic sbPush(input string tag, input logic [31:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic sbCheck(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // One clkEn pulse followed by one idle clk; returns on a negedge
  task automatic step(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk) clkEn = 1'b1;
      @(negedge clk) clkEn = 1'b0;
      enCount++;
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    iWE = 1'b1; iAddr = a; iData = d;
    @(negedge clk);
    iWE = 1'b0;
  endtask

  task automatic measure(input logic [ENV_W-1:0] target, output int cnt);
    cnt = 0;
    while (oEnv !== target && cnt < BUDGET) begin
      step(1);
      cnt++;
    end
  endtask

  // With every rate at 0 the rate counter ticks on enCount multiples of 9
  task automatic stepToPhase();
    while (enCount % 9 != 8) step(1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    iRstN = 1'b0; clkEn = 1'b0; iWE = 1'b0; iAddr = '0; iData = '0; iVoice = 12'h800;
    repeat (3) @(negedge clk);
    sbPush("rst_env", 32'h0);     sbCheck(32'(oEnv));
    sbPush("rst_out", 32'h0);     sbCheck(32'(oOut));
    sbPush("rst_state", 32'(RELEASE)); sbCheck(32'(dut.state));
    iRstN = 1'b1;
    enCount = 0;

    // Gate write aimed at another voice's control register
    wr(ADDR_W'(REG_CTRL), 8'h01);
    sbPush("foreign_gate", 32'h0);
    step(18);
    sbCheck(32'(oEnv));

    // Reset mid-attack
    iVoice = 12'hfff;
    wr(A_CTRL, 8'h01);
    sbPush("atk_to_40", 32'd576);
    measure(8'h40, n); sbCheck(32'(n));
    @(negedge clk);
    sbPush("vca_env40", 32'h1ff);  // 2047*64 >>> 8 = 511
    sbCheck(32'(oOut));
    #3 iRstN = 1'b0;
    #1;
    sbPush("async_rst_env", 32'h0);       sbCheck(32'(oEnv));
    sbPush("async_rst_out", 32'h0);       sbCheck(32'(oOut));
    sbPush("async_rst_state", 32'(RELEASE)); sbCheck(32'(dut.state));
    @(negedge clk);
    iRstN = 1'b1;
    enCount = 0;

    // Attack to peak at rate 0, then decay to sustain 'h88
    wr(A_SR, 8'h80);
    wr(A_CTRL, 8'h01);
    sbPush("atk_first_step", 32'd9);
    measure(8'h01, n); sbCheck(32'(n));
    sbPush("atk_to_peak", 32'd2286);
    measure(8'hff, n); sbCheck(32'(n));
    sbPush("peak_state", 32'(DECAY)); sbCheck(32'(dut.state));
    sbPush("dec_first_step", 32'd9);
    measure(8'hfe, n); sbCheck(32'(n));
    sbPush("dec_to_sustain", 32'd1062);
    measure(8'h88, n); sbCheck(32'(n));
    sbPush("sustain_hold", 32'h88);
    step(200); sbCheck(32'(oEnv));
    wr(A_SR, 8'hf0);
    sbPush("sustain_raised_hold", 32'h88);
    step(30); sbCheck(32'(oEnv));

    // Gate edges coinciding with rate ticks: state changes, env does not
    stepToPhase();
    wr(A_CTRL, 8'h00);
    sbPush("fall_on_tick_env", 32'h88);
    step(1); sbCheck(32'(oEnv));
    sbPush("fall_state", 32'(RELEASE)); sbCheck(32'(dut.state));
    sbPush("rel_step", 32'h87);
    step(9); sbCheck(32'(oEnv));
    stepToPhase();
    wr(A_CTRL, 8'h01);
    sbPush("rise_on_tick_env", 32'h87);
    step(1); sbCheck(32'(oEnv));
    sbPush("rise_state", 32'(ATTACK)); sbCheck(32'(dut.state));
    sbPush("rise_next_tick", 32'h88);
    step(9); sbCheck(32'(oEnv));

    // Back to peak; sustain 'hf holds env at 'hff for the VCA checks
    sbPush("reattack_to_peak", 32'd1071);
    measure(8'hff, n); sbCheck(32'(n));
    @(negedge clk) iVoice = 12'hfff;
    sbPush("vca_fff", 32'h7f7);  // 2047*255 >>> 8 = 2039
    @(negedge clk) sbCheck(32'(oOut));
    iVoice = 12'h800;
    sbPush("vca_800", 32'h000);
    @(negedge clk) sbCheck(32'(oOut));
    iVoice = 12'h000;
    sbPush("vca_000", 32'h808);  // -2048*255 >>> 8 = -2040
    @(negedge clk) sbCheck(32'(oOut));
    iVoice = 12'h123;
    sbPush("vca_123", 32'h929);  // -1757*255 >>> 8 = -1751
    @(negedge clk) sbCheck(32'(oOut));
    sbPush("peak_hold", 32'hff);
    step(20); sbCheck(32'(oEnv));

    // Release from 'h20 through every divisor band down to zero
    @(negedge clk) iRstN = 1'b0;
    @(negedge clk) iRstN = 1'b1;
    enCount = 0;
    wr(A_CTRL, 8'h01);
    sbPush("atk_to_20", 32'd288);
    measure(8'h20, n); sbCheck(32'(n));
    wr(A_CTRL, 8'h00);
    sbPush("rel_20_1f_d4", 32'd36);
    measure(8'h1f, n); sbCheck(32'(n));
    sbPush("rel_1f_1b_d4", 32'd144);
    measure(8'h1b, n); sbCheck(32'(n));
    sbPush("rel_1b_1a_d4", 32'd36);
    measure(8'h1a, n); sbCheck(32'(n));
    sbPush("rel_1a_19_d8", 32'd72);
    measure(8'h19, n); sbCheck(32'(n));
    sbPush("rel_19_0f_d8", 32'd720);
    measure(8'h0f, n); sbCheck(32'(n));
    sbPush("rel_0f_0e_d8", 32'd72);
    measure(8'h0e, n); sbCheck(32'(n));
    sbPush("rel_0e_07_d16", 32'd1008);
    measure(8'h07, n); sbCheck(32'(n));
    sbPush("rel_07_06_d16", 32'd144);
    measure(8'h06, n); sbCheck(32'(n));
    sbPush("rel_06_00_d30", 32'd1620);
    measure(8'h00, n); sbCheck(32'(n));
    sbPush("rel_floor", 32'h0);
    step(600); sbCheck(32'(oEnv));
    sbPush("rel_floor_state", 32'(RELEASE)); sbCheck(32'(dut.state));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
